// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with an in-order response FIFO and redirect flush.
// Define FETCHQ_BYPASS_EN to forward a kept response straight to decode when the FIFO is empty.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [63:0] inst_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    logic [63:0]   fetch_pc, rsp_pc, new_pc;
    logic [CW-1:0] outstanding, discard, count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [63:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [CW:0]   credit;
    logic          req_fire, rsp_keep, fifo_empty, push, pop;
    assign new_pc = {redirect_pc[63:2], 2'b00};
    // Buffered entries plus kept responses still in flight must fit in the FIFO.
    assign credit = {1'b0, count} + {1'b0, outstanding} - {1'b0, discard};
    assign imem_req_valid = (credit < (CW+1)'(DEPTH)) && !redirect_valid;
    assign imem_req_addr = fetch_pc;
    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_keep = imem_rsp_valid && (discard == '0) && !redirect_valid;
    assign fifo_empty = (count == '0);
    assign pop = !fifo_empty && inst_ready && !redirect_valid;
`ifdef FETCHQ_BYPASS_EN
    logic bypass;
    assign bypass = fifo_empty && rsp_keep;
    assign push = rsp_keep && !(bypass && inst_ready);
    assign inst_valid = !fifo_empty || bypass;
    assign inst_data = !fifo_empty ? mem_data[rd_ptr] : bypass ? imem_rsp_data : '0;
    assign inst_pc = !fifo_empty ? mem_pc[rd_ptr] : bypass ? rsp_pc : '0;
`else
    assign push = rsp_keep;
    assign inst_valid = !fifo_empty;
    assign inst_data = fifo_empty ? '0 : mem_data[rd_ptr];
    assign inst_pc = fifo_empty ? '0 : mem_pc[rd_ptr];
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= new_pc;
                rsp_pc   <= new_pc;
                discard  <= outstanding - CW'(imem_rsp_valid);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 64'd4;
                if (rsp_keep) rsp_pc <= rsp_pc + 64'd4;
                if (imem_rsp_valid && discard != '0) discard <= discard - CW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= rsp_pc;
            mem_data[wr_ptr] <= imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven, directed and randomized checks of fetch_queue against a
// delivery-stream model (epoch-tagged memory, requests/deliveries counted since last redirect).
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam logic [63:0] RESET_PC = 64'h0;
`ifdef FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; int due; int ep; } mreq_t;
    typedef struct { bit ird; bit rv; logic [63:0] ra; bit iv; logic [63:0] ipc; } vec_t;

    mreq_t       mq[$];
    int          cyc, lat, epoch, n_req, n_del, n_kept;
    int          passed, total;
    logic [63:0] exp_pc, exp_req;
    logic        s_rv, s_iv, s_pop;
    logic [63:0] s_ra, s_ipc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    // One clock cycle: drive memory response, sample at negedge, check model, update model.
    task automatic step();
        logic kept_now, hs;
        kept_now = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = mq[0].addr[33:2];
            kept_now = (mq[0].ep == epoch) && !redirect_valid;
        end
        @(negedge clk);
        chk("req_valid", 64'(imem_req_valid), 64'(!redirect_valid && (n_req - n_del < DEPTH)));
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
        chk("inst_valid", 64'(inst_valid), 64'((n_kept - n_del > 0) || (BYP && kept_now)));
        if (inst_valid) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_data", 64'(inst_data), 64'(exp_pc[33:2]));
        end else begin
            chk("idle_pc", inst_pc, 64'h0);
            chk("idle_data", 64'(inst_data), 64'h0);
        end
        s_rv = imem_req_valid; s_ra = imem_req_addr;
        s_iv = inst_valid; s_ipc = inst_pc;
        s_pop = inst_valid && inst_ready && !redirect_valid;
        hs = imem_req_valid && imem_req_ready;
        if (imem_rsp_valid) void'(mq.pop_front());
        if (hs) mq.push_back('{imem_req_addr, cyc + lat, epoch});
        if (redirect_valid) begin
            epoch++; n_req = 0; n_del = 0; n_kept = 0;
            exp_pc = {redirect_pc[63:2], 2'b00};
            exp_req = exp_pc;
        end else begin
            if (hs) begin n_req++; exp_req += 64'd4; end
            if (kept_now) n_kept++;
            if (s_pop) begin n_del++; exp_pc += 64'd4; end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mq.delete();
        imem_rsp_valid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0; imem_req_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_inst_valid", 64'(inst_valid), 64'h0);
        chk("reset_inst_pc", inst_pc, 64'h0);
        rst = 1'b1;
        epoch++; n_req = 0; n_del = 0; n_kept = 0;
        exp_pc = RESET_PC; exp_req = RESET_PC;
    endtask

    task automatic drain();
        redirect_valid = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b1;
        repeat (8) step();
    endtask

    task automatic redirect_to(input logic [63:0] pc);
        redirect_valid = 1'b1; redirect_pc = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    // Step until decode consumes an instruction, then compare its PC.
    task automatic next_pc(input string name, input logic [63:0] exp);
        bit got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            step();
            got = s_pop;
        end
        if (got) chk(name, s_ipc, exp);
        else begin
            total++;
            $display("FAIL %s: no instruction within 30 cycles, expected pc %h", name, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        int pops;
        tbl[0]  = '{1'b0, 1'b1, 64'd0,  1'b0, 64'd0};
        tbl[1]  = '{1'b0, 1'b1, 64'd4,  BYP,  64'd0};
        tbl[2]  = '{1'b0, 1'b1, 64'd8,  1'b1, 64'd0};
        tbl[3]  = '{1'b0, 1'b1, 64'd12, 1'b1, 64'd0};
        tbl[4]  = '{1'b0, 1'b0, 64'd0,  1'b1, 64'd0};
        tbl[5]  = '{1'b0, 1'b0, 64'd0,  1'b1, 64'd0};
        tbl[6]  = '{1'b1, 1'b0, 64'd0,  1'b1, 64'd0};
        tbl[7]  = '{1'b1, 1'b1, 64'd16, 1'b1, 64'd4};
        tbl[8]  = '{1'b1, 1'b1, 64'd20, 1'b1, 64'd8};
        tbl[9]  = '{1'b1, 1'b1, 64'd24, 1'b1, 64'd12};
        tbl[10] = '{1'b1, 1'b1, 64'd28, 1'b1, 64'd16};
        passed = 0; total = 0; cyc = 0; epoch = 0; lat = 1;
        do_reset();

        // Backpressure then release, L=1.
        imem_req_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            inst_ready = tbl[i].ird;
            step();
            chk($sformatf("tbl%0d_req_valid", i), 64'(s_rv), 64'(tbl[i].rv));
            if (tbl[i].rv) chk($sformatf("tbl%0d_req_addr", i), s_ra, tbl[i].ra);
            chk($sformatf("tbl%0d_inst_valid", i), 64'(s_iv), 64'(tbl[i].iv));
            if (tbl[i].iv) chk($sformatf("tbl%0d_inst_pc", i), s_ipc, tbl[i].ipc);
        end

        // Sustained one instruction per cycle.
        pops = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i >= 4 && s_pop) pops++;
        end
        chk("throughput", 64'(pops), 64'd8);

        // Redirect with two requests in flight, L=3.
        drain();
        lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
        step(); step();
        redirect_to(64'h100);
        step();
        chk("redir_empty_next", 64'(s_iv), 64'h0);
        chk("redir_req_addr", s_ra, 64'h100);
        next_pc("redir_first_pc", 64'h100);

        // Redirect coinciding with a response and a pop, L=1.
        drain();
        lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        repeat (6) step();
        redirect_to(64'h43);
        chk("sim_valid_at_redirect", 64'(s_iv), 64'h1);
        step();
        chk("sim_empty_next", 64'(s_iv), 64'h0);
        next_pc("sim_first_pc", 64'h40);

        // Back-to-back redirects: last one wins.
        redirect_valid = 1'b1; redirect_pc = 64'h200; step();
        redirect_pc = 64'h300; step();
        redirect_valid = 1'b0;
        next_pc("b2b_first_pc", 64'h300);

        // PC wrap-around.
        redirect_to(64'hFFFF_FFFF_FFFF_FFF8);
        next_pc("wrap0", 64'hFFFF_FFFF_FFFF_FFF8);
        next_pc("wrap1", 64'hFFFF_FFFF_FFFF_FFFC);
        next_pc("wrap2", 64'h0);
        next_pc("wrap3", 64'h4);

        // Randomized traffic per latency, with one asynchronous reset mid-run.
        for (int l = 1; l <= 3; l++) begin
            drain();
            lat = l;
            for (int i = 0; i < 500; i++) begin
                imem_req_ready = ($urandom_range(3) != 0);
                inst_ready = ($urandom_range(2) != 0);
                redirect_valid = ($urandom_range(19) == 0);
                redirect_pc = ($urandom_range(3) == 0) ? {32'hFFFF_FFFF, 24'hFFFFFF, 8'($urandom)}
                                                       : {$urandom, $urandom};
                step();
                if (l == 2 && i == 250) begin
                    #2 rst = 1'b0;
                    #1 chk("async_rst_inst_valid", 64'(inst_valid), 64'h0);
                    chk("async_rst_inst_pc", inst_pc, 64'h0);
                    do_reset();
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
